fp_mac_pipe: RTL and testbench
==============================

Name: fp_mac_pipe

Overview:
Parametrised, pipelined floating-point multiply-accumulate unit. It is the sequential successor to the combinational FP16 multiplier and the core of the MAC datapath. It accepts a stream of operand pairs under a valid/ready handshake and accumulates their products. When an input is tagged last, it emits the accumulated sum. Format is configurable; defaults give IEEE-754 binary16.

Parameters:
EXP_W, 5, exponent field width
MAN_W, 10, stored mantissa (fraction) width
W, 1+EXP_W+MAN_W, total word width (derived localparam, not overridable)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair a/b presented
in_ready  output  1  unit can accept operands this cycle
a  input  W  multiplicand, {sign, exp, frac}
b  input  W  multiplier, same format
first  input  1  this product starts a new accumulation; previous accumulator discarded
last  input  1  this product closes the accumulation; result emitted
out_valid  output  1  result holds a completed sum
out_ready  input  1  downstream accepts result
result  output  W  accumulated sum
overflow  output  1  sticky per-accumulation: some intermediate exponent saturated; valid with out_valid

Behaviour:
- Reset (async assert, sync-released internally by the flops' clocking):
  - in_ready=0 while rst_n low, 1 from the first clk edge after release.
  - out_valid=0, result=0, overflow=0.
  - Accumulator, all stage valids and tags cleared.
- Handshake:
  - Transfer when in_valid&&in_ready; similarly out_valid&&out_ready.
  - in_ready = !(out_valid && !out_ready). This is a global stall: all stages hold while the output is blocked.
  - result/out_valid/overflow stay stable until accepted.
- Pipeline: 2 stages.
  - Stage M registers the product: sign xor; exponent sum minus bias (2^(EXP_W-1)-1); mantissa product of hidden-bit-extended fractions, normalised by at most 1 shift, truncated to MAN_W. first/last tags travel with it.
  - Stage A: acc_next = first ? prod : acc + prod.
    - Addition aligns the smaller operand by exponent difference (shift saturates at MAN_W+3 → contributes 0).
    - Magnitude add/sub with leading-zero normalisation; truncate.
  - If last: result<=acc_next, out_valid<=1, accumulator cleared, overflow captured and then cleared.
- Latency: operand pair with last accepted at edge N → out_valid high after edge N+2, with no stall. Throughput is 1 pair/cycle.
- Number rules:
  - Rounding is round-toward-zero (truncation) everywhere.
  - Subnormal inputs, and zero-exponent inputs, are treated as zero. Results that underflow flush to +0.
  - Exact cancellation yields +0.
  - Exponent ≥ all-ones (product or sum) saturates to ±Inf (exp all-ones, frac 0) and sets overflow.
  - Inf inputs propagate as Inf with the computed sign. Inf + (−Inf) → +Inf, overflow set. NaN is not supported; exp-all-ones inputs are treated as Inf.
- Boundaries:
  - first&&last on the same pair → result = that product alone.
  - Product arriving with neither first nor last and no open accumulation: added to accumulator (cleared value 0).
  - first asserted mid-accumulation: silently restarts; prior partial sum dropped, no output.
  - Reset mid-accumulation: all in-flight data lost, no spurious out_valid.
  - Output stall while a new last product sits in stage A: held; no overwrite of unaccepted result.

Decomposition:
- Shared package fp_pkg: EXP_W/MAN_W defaults, bias function, field-extract functions, fp_unpacked_t struct {sign, exp, mant-with-hidden}, INF/ZERO constant builders.
- One sub-module, fp_add_norm: combinational align/add/normalise/truncate with overflow flag. It is reused later by a standalone adder. The multiply path stays inline in fp_mac_pipe.

Test Plan:
1. Single product: a=0x3E00 (1.5), b=0x4000 (2.0), first=last=1 → result=0x4200 (3.0) two cycles later, overflow=0.
2. Accumulate 4 pairs: 0x3C00×0x3C00, back-to-back, first on #1, last on #4 → single output 0x4400 (4.0), out_valid exactly one cycle.
3. Cancellation: 0x3C00×0x3C00 (first), then 0xBC00×0x3C00 (last) → result=0x0000.
4. Overflow: 0x7BFF×0x7BFF, first=last=1 → result=0x7C00, overflow=1. The next accumulation (1.0×1.0) → 0x3C00, overflow=0.
5. Backpressure: two consecutive single-product jobs (1.5×2.0, then 2.0×2.0) with out_ready=0 for 5 cycles → in_ready drops, result 0x4200 held stable. After release, 0x4200 is accepted, then 0x4400; nothing lost or duplicated.
6. Subnormal/reset: 0x0001×0x3C00 → 0x0000. Assert rst_n low mid 4-pair accumulation → outputs 0 immediately, no out_valid after release.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point format helpers
package fp_pkg;
    localparam int DEF_EXP_W = 5;
    localparam int DEF_MAN_W = 10;

    // Widest fields any instantiated format may use (word <= 64 bits).
    localparam int XW = 16;
    localparam int MW = 32;

    typedef struct packed {
        logic          sign;
        logic [XW-1:0] exp;
        logic [MW-1:0] mant;    // hidden bit included; zero for zero/subnormal
    } fp_unpacked_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic fp_unpacked_t fp_unpack(input logic [63:0] word, input int exp_w,
                                               input int man_w);
        fp_unpacked_t u;
        logic [63:0]  emask;
        logic [63:0]  mmask;
        emask  = (64'd1 << exp_w) - 64'd1;
        mmask  = (64'd1 << man_w) - 64'd1;
        u.sign = ((word >> (exp_w + man_w)) & 64'd1) != 64'd0;
        u.exp  = XW'((word >> man_w) & emask);
        u.mant = (u.exp == '0) ? '0 : MW'((word & mmask) | (64'd1 << man_w));
        return u;
    endfunction

    function automatic logic [63:0] fp_inf(input logic sign, input int exp_w, input int man_w);
        return ({63'd0, sign} << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

    function automatic logic [63:0] fp_zero();
        return 64'd0;
    endfunction
endpackage

// File: rtl/fp_add_norm.sv
// rtl/fp_add_norm.sv - combinational align/add/normalise/truncate
module fp_add_norm
    import fp_pkg::*;
#(
    parameter int  EXP_W = DEF_EXP_W,
    parameter int  MAN_W = DEF_MAN_W,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         ovf
);
    // carry bit + hidden bit + fraction + 3 guard bits
    localparam int SW   = MAN_W + 5;
    localparam int EMAX = (1 << EXP_W) - 1;

    fp_unpacked_t  ux, uy, big, sml;
    logic [SW-1:0] mb, ms, s, norm;
    logic          x_inf, y_inf, found;
    int            d, lz, e;

    // Larger magnitude sets sign and exponent; the smaller one is shifted into alignment.
    always_comb begin
        ux    = fp_unpack(64'(x), EXP_W, MAN_W);
        uy    = fp_unpack(64'(y), EXP_W, MAN_W);
        x_inf = (ux.exp == XW'(EMAX));
        y_inf = (uy.exp == XW'(EMAX));
        if ({ux.exp, ux.mant} >= {uy.exp, uy.mant}) begin
            big = ux;
            sml = uy;
        end else begin
            big = uy;
            sml = ux;
        end
        d  = int'(big.exp) - int'(sml.exp);
        mb = SW'({big.mant, 3'b000});
        ms = (d >= MAN_W + 3) ? '0 : (SW'({sml.mant, 3'b000}) >> d);
        s  = (big.sign == sml.sign) ? (mb + ms) : (mb - ms);
        lz    = 0;
        found = 1'b0;
        for (int i = SW - 2; i >= 0; i--) begin
            if (!found) begin
                if (s[i]) found = 1'b1;
                else      lz    = lz + 1;
            end
        end
        if (s[SW-1]) begin
            norm = s >> 1;
            e    = int'(big.exp) + 1;
        end else begin
            norm = s << lz;
            e    = int'(big.exp) - lz;
        end
        sum = W'(fp_zero());
        ovf = 1'b0;
        if (x_inf || y_inf) begin
            if (x_inf && y_inf && (ux.sign != uy.sign)) begin
                sum = W'(fp_inf(1'b0, EXP_W, MAN_W));
                ovf = 1'b1;
            end else begin
                sum = W'(fp_inf(x_inf ? ux.sign : uy.sign, EXP_W, MAN_W));
            end
        end else if (s == '0) begin
            sum = W'(fp_zero());
        end else if (e >= EMAX) begin
            sum = W'(fp_inf(big.sign, EXP_W, MAN_W));
            ovf = 1'b1;
        end else if (e > 0) begin
            sum = {big.sign, EXP_W'(e), MAN_W'(norm >> 3)};
        end
    end
endmodule

// File: rtl/fp_mac_pipe.sv
// rtl/fp_mac_pipe.sv - pipelined floating-point multiply-accumulate
module fp_mac_pipe
    import fp_pkg::*;
#(
    parameter int  EXP_W = DEF_EXP_W,
    parameter int  MAN_W = DEF_MAN_W,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         first,
    input  logic         last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow
);
    localparam int PW   = 2 * (MAN_W + 1);
    localparam int EMAX = (1 << EXP_W) - 1;

    logic          ready_q, stall, take;
    logic          s0_valid, s0_first, s0_last;
    logic [W-1:0]  s0_a, s0_b;
    logic          s1_valid, s1_first, s1_last, s1_ovf;
    logic [W-1:0]  s1_prod;
    logic [W-1:0]  acc, acc_x, acc_next;
    logic          acc_ovf, add_ovf, ovf_next;
    fp_unpacked_t  ua, ub;
    logic [PW-1:0] pm, pn;
    logic [W-1:0]  prod;
    logic          prod_ovf;
    int            pe;

    // A blocked result freezes every stage.
    assign stall    = out_valid && !out_ready;
    assign in_ready = ready_q && !stall;
    assign take     = in_valid && in_ready;

    // Multiply the captured operands: one-step normalise, truncate, saturate or flush.
    always_comb begin
        ua = fp_unpack(64'(s0_a), EXP_W, MAN_W);
        ub = fp_unpack(64'(s0_b), EXP_W, MAN_W);
        pm = PW'(ua.mant) * PW'(ub.mant);
        pe = int'(ua.exp) + int'(ub.exp) - fp_bias(EXP_W);
        if (pm[PW-1]) begin
            pn = pm;
            pe = pe + 1;
        end else begin
            pn = pm << 1;
        end
        prod     = W'(fp_zero());
        prod_ovf = 1'b0;
        if (ua.exp == XW'(EMAX) || ub.exp == XW'(EMAX)) begin
            prod = W'(fp_inf(ua.sign ^ ub.sign, EXP_W, MAN_W));
        end else if (ua.mant == '0 || ub.mant == '0) begin
            prod = W'(fp_zero());
        end else if (pe >= EMAX) begin
            prod     = W'(fp_inf(ua.sign ^ ub.sign, EXP_W, MAN_W));
            prod_ovf = 1'b1;
        end else if (pe > 0) begin
            prod = {ua.sign ^ ub.sign, EXP_W'(pe), MAN_W'(pn >> (PW - 1 - MAN_W))};
        end
    end

    assign acc_x    = s1_first ? '0 : acc;
    assign ovf_next = (acc_ovf && !s1_first) || s1_ovf || add_ovf;

    fp_add_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_add (
        .x   (acc_x),
        .y   (s1_prod),
        .sum (acc_next),
        .ovf (add_ovf)
    );

    // Input side stays closed until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    // Operand capture and product stage, both held during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_prod  <= '0;
        end else if (!stall) begin
            s0_valid <= take;
            if (take) begin
                s0_a     <= a;
                s0_b     <= b;
                s0_first <= first;
                s0_last  <= last;
            end
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_prod  <= prod;
                s1_ovf   <= prod_ovf;
                s1_first <= s0_first;
                s1_last  <= s0_last;
            end
        end
    end

    // Accumulate, and on a closing product publish the sum and reopen empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (!stall && s1_valid) begin
                if (s1_last) begin
                    result    <= acc_next;
                    overflow  <= ovf_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    acc_ovf   <= 1'b0;
                end else begin
                    acc     <= acc_next;
                    acc_ovf <= ovf_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_mac_pipe.sv
// tb/tb_fp_mac_pipe.sv - self-checking bench for fp_mac_pipe
module tb_fp_mac_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        first = 1'b0;
    logic        last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int njob   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        first;
        logic        last;
        logic [15:0] res;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          id;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    fp_mac_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .first     (first),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vf,
                                input logic vl, input logic [15:0] vr, input logic vo);
        vec_t v;
        v.a = va; v.b = vb; v.first = vf; v.last = vl; v.res = vr; v.ovf = vo;
        return v;
    endfunction

    task automatic send(input vec_t v);
        int   guard = 0;
        exp_t e;
        a = v.a; b = v.b; first = v.first; last = v.last; in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
        end else begin
            @(posedge clk); #1;
            if (v.last) begin
                e.res = v.res; e.ovf = v.ovf; e.id = njob;
                sb.push_back(e);
                njob++;
            end
        end
        in_valid = 1'b0; first = 1'b0; last = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard: every accepted result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: result %h with no outstanding job", result);
            end else begin
                e = sb.pop_front();
                check($sformatf("result_job%0d", e.id), 32'(result), 32'(e.res));
                check($sformatf("overflow_job%0d", e.id), 32'(overflow), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;

        // single products
        tbl.push_back(mk(16'h3E00, 16'h4000, 1, 1, 16'h4200, 0));
        tbl.push_back(mk(16'h3C00, 16'h3C00, 1, 1, 16'h3C00, 0));
        tbl.push_back(mk(16'hC000, 16'h4000, 1, 1, 16'hC400, 0));
        tbl.push_back(mk(16'hBC00, 16'hBC00, 1, 1, 16'h3C00, 0));
        tbl.push_back(mk(16'h3555, 16'h3C00, 1, 1, 16'h3555, 0));
        tbl.push_back(mk(16'h3E00, 16'h3E00, 1, 1, 16'h4080, 0));
        tbl.push_back(mk(16'h3C01, 16'h3C01, 1, 1, 16'h3C02, 0));
        tbl.push_back(mk(16'h3800, 16'h3800, 1, 1, 16'h3400, 0));
        tbl.push_back(mk(16'h0001, 16'h3C00, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(16'h0400, 16'h0400, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(16'h7BFF, 16'h7BFF, 1, 1, 16'h7C00, 1));
        tbl.push_back(mk(16'h3C00, 16'h3C00, 1, 1, 16'h3C00, 0));
        // four-pair accumulation -> 4.0
        tbl.push_back(mk(16'h3C00, 16'h3C00, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h3C00, 16'h3C00, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h3C00, 16'h3C00, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h3C00, 16'h3C00, 0, 1, 16'h4400, 0));
        // exact cancellation -> +0
        tbl.push_back(mk(16'h3C00, 16'h3C00, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(16'hBC00, 16'h3C00, 0, 1, 16'h0000, 0));
        // 1.5 - 1.0 needs a left normalise -> 0.5
        tbl.push_back(mk(16'h3E00, 16'h3C00, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(16'hBC00, 16'h3C00, 0, 1, 16'h3800, 0));
        // max + max saturates in the adder
        tbl.push_back(mk(16'h7BFF, 16'h3C00, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h7BFF, 16'h3C00, 0, 1, 16'h7C00, 1));
        // first mid-accumulation restarts: 3.0 + 1.0
        tbl.push_back(mk(16'h3C00, 16'h3C00, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h3C00, 16'h3C00, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h3E00, 16'h4000, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h3C00, 16'h3C00, 0, 1, 16'h4400, 0));
        // alignment by 10 keeps the addend, by 13 drops it
        tbl.push_back(mk(16'h3C00, 16'h3C00, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h1400, 16'h3C00, 0, 1, 16'h3C01, 0));
        tbl.push_back(mk(16'h3C00, 16'h3C00, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h0800, 16'h3C00, 0, 1, 16'h3C00, 0));
        // 1.0 - 2^-12 truncates toward zero
        tbl.push_back(mk(16'h3C00, 16'h3C00, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h8C00, 16'h3C00, 0, 1, 16'h3BFF, 0));
        // +Inf + -Inf -> +Inf with overflow
        tbl.push_back(mk(16'h7BFF, 16'h7BFF, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(16'hFBFF, 16'h7BFF, 0, 1, 16'h7C00, 1));

        // reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("release_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("release_in_ready_high", 32'(in_ready), 32'd1);

        // vector table, back to back
        for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
        drain();

        // latency: last accepted at edge N, out_valid after N+2
        send(mk(16'h3E00, 16'h4000, 1, 1, 16'h4200, 0));
        check("lat_n0", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_n1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_n2", 32'(out_valid), 32'd1);
        drain();

        // backpressure: two single-product jobs behind a blocked output
        out_ready = 1'b0;
        send(mk(16'h3E00, 16'h4000, 1, 1, 16'h4200, 0));
        send(mk(16'h4000, 16'h4000, 1, 1, 16'h4400, 0));
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_result_%0d", i), 32'(result), 32'h4200);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        // asynchronous reset in the middle of an accumulation
        send(mk(16'h3C00, 16'h3C00, 1, 0, 16'h0000, 0));
        send(mk(16'h3C00, 16'h3C00, 0, 0, 16'h0000, 0));
        send(mk(16'h3C00, 16'h3C00, 0, 0, 16'h0000, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("post_rst_no_output", 32'(seen), 32'd0);

        // untagged product after reset adds to a cleared accumulator
        send(mk(16'h3C00, 16'h3C00, 0, 0, 16'h0000, 0));
        send(mk(16'h3C00, 16'h3C00, 0, 1, 16'h4000, 0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
